stopwatch_digits: RTL

- 4-digit MM:SS BCD stopwatch; upstream stage that drives the digit0..digit3 inputs of the seven-segment display driver.
- Counts on an external 1 Hz enable pulse.
- Controlled by two raw push-buttons (start/stop, clear). Each button is synchronised, debounced and edge-detected inside the block.

---
 rtl/stopwatch_digits.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_digits.sv
// -----------------------------------------------------------------------------
// stopwatch_digits
//   Four-digit MM:SS BCD stopwatch feeding the seven-segment display driver.
//   Counts on a one-cycle 1 Hz enable pulse. Two raw push-buttons
//   (start/stop, clear) are each synchronised, debounced and edge-detected
//   here, so the buttons can be wired straight to the pins.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   tick           one-cycle count enable, synchronous to clk
//   btn_start_stop raw asynchronous button, active-high
//   btn_clear      raw asynchronous button, active-high
//   digit0         seconds units  (BCD 0-9)
//   digit1         seconds tens   (BCD 0-5)
//   digit2         minutes units  (BCD 0-9)
//   digit3         minutes tens   (BCD 0-5)
//   running        high while the stopwatch is in RUN
//
// There is no valid/ready handshake: tick and the button press events are
// single-cycle qualifiers that act on the edge at which they are sampled.
// -----------------------------------------------------------------------------
module stopwatch_digits #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  // Bit 0 = start/stop, bit 1 = clear.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  assign raw = {btn_clear, btn_start_stop};

  // Synchroniser, debounce and rising-edge detection for both buttons.
  // The press pulse is registered so the state reacts DEBOUNCE_CYCLES+3
  // edges after the raw level is first sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  logic ss_ev;
  logic clr_ev;
  assign ss_ev  = press[0];
  assign clr_ev = press[1];

  logic [1:0] state;
  logic [1:0] state_next;

  // Clear wins over start/stop when both events land on the same cycle.
  always_comb begin
    state_next = state;
    if (clr_ev) begin
      state_next = IDLE;
    end else if (ss_ev) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Ripple-carry BCD increment over MM:SS, wrapping 59:59 -> 00:00.
  logic       c0;
  logic       c1;
  logic       c2;
  logic [3:0] inc0;
  logic [3:0] inc1;
  logic [3:0] inc2;
  logic [3:0] inc3;

  always_comb begin
    c0   = (digit0 == 4'd9);
    c1   = c0 && (digit1 == 4'd5);
    c2   = c1 && (digit2 == 4'd9);
    inc0 = c0 ? 4'd0 : digit0 + 4'd1;
    inc1 = c0 ? ((digit1 == 4'd5) ? 4'd0 : digit1 + 4'd1) : digit1;
    inc2 = c1 ? ((digit2 == 4'd9) ? 4'd0 : digit2 + 4'd1) : digit2;
    inc3 = c2 ? ((digit3 == 4'd5) ? 4'd0 : digit3 + 4'd1) : digit3;
  end

  // Counting uses the current state, so a tick on the RUN->PAUSE edge is
  // counted while a tick on the edge that enters RUN is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
      digit0  <= 4'd0;
      digit1  <= 4'd0;
      digit2  <= 4'd0;
      digit3  <= 4'd0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      if (clr_ev) begin
        digit0 <= 4'd0;
        digit1 <= 4'd0;
        digit2 <= 4'd0;
        digit3 <= 4'd0;
      end else if ((state == RUN) && tick) begin
        digit0 <= inc0;
        digit1 <= inc1;
        digit2 <= inc2;
        digit3 <= inc3;
      end
    end
  end

endmodule
